// File: rtl/filter_path_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// filter_path_ctrl
//
// Frame-synchronous controller for the 3x3 matrix / Gaussian filter datapath.
// Measures the active geometry of the incoming video and declares timing lock
// after a run of consistent frames. The filter/bypass select only changes at
// frame start, and a line-buffer clear pulse is issued whenever the filtered
// path is (re)engaged.
//
// Ports:
//   video_clk    pixel clock, all logic on its rising edge
//   rst_n        asynchronous active-low reset
//   init_over    HDMI configuration done; low holds the block idle
//   video_vs     vertical sync, active level set by VS_POL
//   video_hs     horizontal sync (monitored only)
//   video_de     data enable
//   filt_en_req  level request: 1 = filtered path, 0 = bypass
//   filt_sel     registered path select to the output mux (1 = filter)
//   lb_clr       one-cycle line-buffer clear pulse
//   timing_lock  geometry stable
//   act_width    last locked active pixels per line
//   act_height   last locked active lines per frame
//   frame_err    one-cycle pulse when a locked geometry is lost
// -----------------------------------------------------------------------------
module filter_path_ctrl #(
    parameter int W_BITS      = 12,
    parameter int LOCK_FRAMES = 3,
    parameter bit VS_POL      = 1'b1
) (
    input  logic              video_clk,
    input  logic              rst_n,
    input  logic              init_over,
    input  logic              video_vs,
    input  logic              video_hs,
    input  logic              video_de,
    input  logic              filt_en_req,
    output logic              filt_sel,
    output logic              lb_clr,
    output logic              timing_lock,
    output logic [W_BITS-1:0] act_width,
    output logic [W_BITS-1:0] act_height,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_MEASURE   = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    localparam logic [W_BITS-1:0] CNT_ZERO = {W_BITS{1'b0}};
    localparam logic [W_BITS-1:0] CNT_ONE  = {{(W_BITS-1){1'b0}}, 1'b1};
    localparam logic [W_BITS-1:0] CNT_MAX  = {W_BITS{1'b1}};
    // Number of matches (frame-to-frame comparisons) needed to lock.
    localparam logic [4:0]        LOCK_M1  = 5'(LOCK_FRAMES - 1);

    state_t             state_r;
    state_t             state_nxt_s;

    logic               vs_act_s;
    logic               vs_d_r;
    logic               fs_r;
    logic               de_d_r;
    logic               de_fall_s;
    logic               de_rise_s;
    logic               req_meta_r;
    logic               req_sync_r;

    logic [W_BITS-1:0]  pix_cnt_r;
    logic [W_BITS-1:0]  line_cnt_r;
    logic [W_BITS-1:0]  cur_w_r;
    logic               line_bad_r;
    logic [W_BITS-1:0]  prev_w_r;
    logic [W_BITS-1:0]  prev_h_r;
    logic [3:0]         match_cnt_r;

    logic [W_BITS-1:0]  cur_w_eff_s;
    logic               line_bad_eff_s;
    logic               good_s;
    logic               match_s;
    logic               lock_hit_s;

    logic               lock_trans_s;
    logic               err_trans_s;
    logic               filt_sel_nxt_s;
    logic               lb_clr_nxt_s;
    logic               timing_lock_nxt_s;

    logic               filt_sel_r;
    logic               lb_clr_r;
    logic               timing_lock_r;
    logic               frame_err_r;
    logic [W_BITS-1:0]  act_width_r;
    logic [W_BITS-1:0]  act_height_r;

    // hs is observed only; it takes no part in measurement.
    logic               unused_hs_s;
    assign unused_hs_s = video_hs;

    assign vs_act_s  = VS_POL ? video_vs : ~video_vs;
    assign de_fall_s = de_d_r & ~video_de;
    assign de_rise_s = video_de & ~de_d_r;

    // A line ending in the fs cycle still belongs to the frame being evaluated,
    // so the evaluation uses the values as they would be after that line.
    assign cur_w_eff_s    = (de_fall_s && (cur_w_r == CNT_ZERO)) ? pix_cnt_r : cur_w_r;
    assign line_bad_eff_s = line_bad_r |
                            (de_fall_s && (cur_w_r != CNT_ZERO) && (pix_cnt_r != cur_w_r));
    assign good_s         = !line_bad_eff_s && (cur_w_eff_s != CNT_ZERO) &&
                            (line_cnt_r != CNT_ZERO);
    assign match_s        = good_s && (cur_w_eff_s == prev_w_r) && (line_cnt_r == prev_h_r);
    assign lock_hit_s     = match_s && (({1'b0, match_cnt_r} + 5'd1) >= LOCK_M1);

    // Sync edge detection, de history and request double-flop.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d_r     <= 1'b0;
            fs_r       <= 1'b0;
            de_d_r     <= 1'b0;
            req_meta_r <= 1'b0;
            req_sync_r <= 1'b0;
        end else begin
            vs_d_r     <= vs_act_s;
            fs_r       <= vs_act_s & ~vs_d_r;
            de_d_r     <= video_de;
            req_meta_r <= filt_en_req;
            req_sync_r <= req_meta_r;
        end
    end

    // Pixel and line counters plus per-frame width consistency tracking.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_r  <= CNT_ZERO;
            line_cnt_r <= CNT_ZERO;
            cur_w_r    <= CNT_ZERO;
            line_bad_r <= 1'b0;
        end else begin
            if (video_de) begin
                pix_cnt_r <= (pix_cnt_r != CNT_MAX) ? (pix_cnt_r + CNT_ONE) : pix_cnt_r;
            end else begin
                pix_cnt_r <= CNT_ZERO;
            end

            // A line starting in the fs cycle is the first line of the new frame.
            if (fs_r) begin
                line_cnt_r <= de_rise_s ? CNT_ONE : CNT_ZERO;
            end else if (de_rise_s && (line_cnt_r != CNT_MAX)) begin
                line_cnt_r <= line_cnt_r + CNT_ONE;
            end else begin
                line_cnt_r <= line_cnt_r;
            end

            if (fs_r) begin
                cur_w_r    <= CNT_ZERO;
                line_bad_r <= 1'b0;
            end else if (de_fall_s) begin
                if (cur_w_r == CNT_ZERO) begin
                    cur_w_r <= pix_cnt_r;
                end else if (pix_cnt_r != cur_w_r) begin
                    line_bad_r <= 1'b1;
                end else begin
                    cur_w_r <= cur_w_r;
                end
            end else begin
                cur_w_r    <= cur_w_r;
                line_bad_r <= line_bad_r;
            end
        end
    end

    // Previous-frame geometry and match run length. A bad frame is not kept as
    // a reference, and re-initialisation forgets the history entirely.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_w_r    <= CNT_ZERO;
            prev_h_r    <= CNT_ZERO;
            match_cnt_r <= 4'd0;
        end else begin
            if (state_r == ST_WAIT_INIT) begin
                prev_w_r <= CNT_ZERO;
                prev_h_r <= CNT_ZERO;
            end else if (fs_r) begin
                prev_w_r <= good_s ? cur_w_eff_s : CNT_ZERO;
                prev_h_r <= good_s ? line_cnt_r  : CNT_ZERO;
            end else begin
                prev_w_r <= prev_w_r;
                prev_h_r <= prev_h_r;
            end

            if ((state_r != ST_MEASURE) || (state_nxt_s != ST_MEASURE)) begin
                match_cnt_r <= 4'd0;
            end else if (fs_r) begin
                if (match_s) begin
                    match_cnt_r <= (match_cnt_r != 4'hF) ? (match_cnt_r + 4'd1) : match_cnt_r;
                end else begin
                    match_cnt_r <= 4'd0;
                end
            end else begin
                match_cnt_r <= match_cnt_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_WAIT_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; loss of init_over wins over frame events.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_WAIT_INIT: begin
                if (init_over) state_nxt_s = ST_MEASURE;
                else           state_nxt_s = ST_WAIT_INIT;
            end
            ST_MEASURE: begin
                if (!init_over)              state_nxt_s = ST_WAIT_INIT;
                else if (fs_r && lock_hit_s) state_nxt_s = ST_LOCKED;
                else                         state_nxt_s = ST_MEASURE;
            end
            ST_LOCKED: begin
                if (!init_over)            state_nxt_s = ST_WAIT_INIT;
                else if (fs_r && !match_s) state_nxt_s = ST_MEASURE;
                else                       state_nxt_s = ST_LOCKED;
            end
            default: begin
                state_nxt_s = ST_WAIT_INIT;
            end
        endcase
    end

    // FSM output decode: next values of the registered outputs.
    always_comb begin
        lock_trans_s      = (state_r == ST_MEASURE) && (state_nxt_s == ST_LOCKED);
        err_trans_s       = (state_r == ST_LOCKED)  && (state_nxt_s == ST_MEASURE);
        timing_lock_nxt_s = (state_nxt_s == ST_LOCKED);
        if (state_nxt_s != ST_LOCKED) begin
            filt_sel_nxt_s = 1'b0;
        end else if (fs_r) begin
            filt_sel_nxt_s = req_sync_r;
        end else begin
            filt_sel_nxt_s = filt_sel_r;
        end
        // Both clear causes collapse into one pulse.
        lb_clr_nxt_s = (filt_sel_nxt_s & ~filt_sel_r) | lock_trans_s;
    end

    // Output registers; act_* only load on lock and otherwise hold.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_sel_r    <= 1'b0;
            lb_clr_r      <= 1'b0;
            timing_lock_r <= 1'b0;
            frame_err_r   <= 1'b0;
            act_width_r   <= CNT_ZERO;
            act_height_r  <= CNT_ZERO;
        end else begin
            filt_sel_r    <= filt_sel_nxt_s;
            lb_clr_r      <= lb_clr_nxt_s;
            timing_lock_r <= timing_lock_nxt_s;
            frame_err_r   <= err_trans_s;
            if (lock_trans_s) begin
                act_width_r  <= cur_w_eff_s;
                act_height_r <= line_cnt_r;
            end else begin
                act_width_r  <= act_width_r;
                act_height_r <= act_height_r;
            end
        end
    end

    assign filt_sel    = filt_sel_r;
    assign lb_clr      = lb_clr_r;
    assign timing_lock = timing_lock_r;
    assign frame_err   = frame_err_r;
    assign act_width   = act_width_r;
    assign act_height  = act_height_r;

endmodule

// File: tb/tb_filter_path_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for filter_path_ctrl: two instances (active-high and
// active-low vs). Stimulus pushes expected output tuples with the cycle in
// which they must appear; a monitor pops one entry on every output change.
module tb_filter_path_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_over;
    logic        filt_en_req;
    logic        hs;
    logic        vs1, de1, vs0, de0;
    logic        tgt;  // 1 = active-high vs instance, 0 = active-low

    logic        fsel_p, lb_p, tl_p, fe_p;
    logic [11:0] aw_p, ah_p;
    logic        fsel_n, lb_n, tl_n, fe_n;
    logic [11:0] aw_n, ah_n;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;

    int          exp_cyc_q[$];
    logic [27:0] exp_val_q[$];

    filter_path_ctrl #(.W_BITS(12), .LOCK_FRAMES(3), .VS_POL(1'b1)) dut_p (
        .video_clk(clk), .rst_n(rst_n), .init_over(init_over),
        .video_vs(vs1), .video_hs(hs), .video_de(de1), .filt_en_req(filt_en_req),
        .filt_sel(fsel_p), .lb_clr(lb_p), .timing_lock(tl_p),
        .act_width(aw_p), .act_height(ah_p), .frame_err(fe_p)
    );

    filter_path_ctrl #(.W_BITS(12), .LOCK_FRAMES(3), .VS_POL(1'b0)) dut_n (
        .video_clk(clk), .rst_n(rst_n), .init_over(init_over),
        .video_vs(vs0), .video_hs(hs), .video_de(de0), .filt_en_req(filt_en_req),
        .filt_sel(fsel_n), .lb_clr(lb_n), .timing_lock(tl_n),
        .act_width(aw_n), .act_height(ah_n), .frame_err(fe_n)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic logic [27:0] pk(input logic fs_v, input logic lb_v, input logic tl_v,
                                       input logic fe_v, input int w, input int h);
        logic [11:0] w12;
        logic [11:0] h12;
        w12 = w[11:0];
        h12 = h[11:0];
        return {fs_v, lb_v, tl_v, fe_v, w12, h12};
    endfunction

    function automatic logic [27:0] obs_p();
        return {fsel_p, lb_p, tl_p, fe_p, aw_p, ah_p};
    endfunction

    function automatic logic [27:0] obs_n();
        return {fsel_n, lb_n, tl_n, fe_n, aw_n, ah_n};
    endfunction

    task automatic push(input int c, input logic [27:0] v);
        exp_cyc_q.push_back(c);
        exp_val_q.push_back(v);
    endtask

    // Monitor: every change of the observed tuple is one DUT event.
    initial begin
        logic [27:0] obs;
        logic [27:0] prev_obs;
        logic [27:0] ev;
        int          ec;
        prev_obs = 28'd0;
        forever begin
            @(negedge clk);
            obs = tgt ? obs_p() : obs_n();
            if (obs !== prev_obs) begin
                n_checks = n_checks + 1;
                if (exp_val_q.size() == 0) begin
                    n_err = n_err + 1;
                    $display("FAIL unexpected_event cyc=%0d got=%h", cyc, obs);
                end else begin
                    ev = exp_val_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    if ((obs !== ev) || (cyc != ec)) begin
                        n_err = n_err + 1;
                        $display("FAIL event got=%h at cyc %0d, required=%h at cyc %0d",
                                 obs, cyc, ev, ec);
                    end
                end
                prev_obs = obs;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vs(input logic active);
        if (tgt) vs1 = active;
        else     vs0 = ~active;
    endtask

    task automatic set_de(input logic v);
        if (tgt) de1 = v;
        else     de0 = v;
    endtask

    // Raise vs; returns the cycle of the drive. Events land at c+2.
    task automatic start_fs(output int c);
        set_vs(1'b1);
        c = cyc;
        step();
    endtask

    // Rest of the frame: vs tail, 3 blank lines, h active lines, 4-cycle blanking.
    task automatic frame_body(input int w, input int h, input int bad_l, input int bad_w);
        step();
        set_vs(1'b0);
        repeat (3 * (w + 4)) step();
        for (int l = 0; l < h; l++) begin
            set_de(1'b1);
            repeat ((l == bad_l) ? bad_w : w) step();
            set_de(1'b0);
            repeat (4) step();
        end
    endtask

    initial begin
        int c;
        rst_n = 1'b1; init_over = 1'b1; filt_en_req = 1'b1; hs = 1'b0;
        vs1 = 1'b0; de1 = 1'b0; vs0 = 1'b1; de0 = 1'b0; tgt = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) step();
        n_checks = n_checks + 1;
        if (obs_p() !== 28'd0) begin
            n_err = n_err + 1;
            $display("FAIL reset_p got=%h required=0", obs_p());
        end
        n_checks = n_checks + 1;
        if (obs_n() !== 28'd0) begin
            n_err = n_err + 1;
            $display("FAIL reset_n got=%h required=0", obs_n());
        end
        rst_n = 1'b1;
        repeat (4) step();

        // Active-low vs instance, 32x4 frames: lock at the 4th fs.
        for (int f = 1; f <= 3; f++) begin
            start_fs(c);
            frame_body(32, 4, -1, 0);
        end
        start_fs(c);
        push(c + 2, pk(1'b1, 1'b1, 1'b1, 1'b0, 32, 4));
        push(c + 3, pk(1'b1, 1'b0, 1'b1, 1'b0, 32, 4));
        frame_body(32, 4, -1, 0);
        // Reset mid-line clears everything asynchronously.
        start_fs(c);
        fork
            frame_body(32, 4, -1, 0);
            begin
                repeat (120) step();
                push(cyc, 28'd0);
                rst_n = 1'b0;
                repeat (3) step();
                rst_n = 1'b1;
            end
        join
        repeat (5) step();

        // Active-high vs instance, 16x8 frames.
        tgt = 1'b1;
        repeat (2) step();
        for (int f = 1; f <= 3; f++) begin
            start_fs(c);
            frame_body(16, 8, -1, 0);
        end
        start_fs(c);                                   // fs4: lock
        push(c + 2, pk(1'b1, 1'b1, 1'b1, 1'b0, 16, 8));
        push(c + 3, pk(1'b1, 1'b0, 1'b1, 1'b0, 16, 8));
        frame_body(16, 8, -1, 0);
        start_fs(c);                                   // fs5: frame with short line 5
        frame_body(16, 8, 4, 15);
        start_fs(c);                                   // fs6: geometry lost
        push(c + 2, pk(1'b0, 1'b0, 1'b0, 1'b1, 16, 8));
        push(c + 3, pk(1'b0, 1'b0, 1'b0, 1'b0, 16, 8));
        frame_body(16, 8, -1, 0);
        for (int f = 7; f <= 8; f++) begin
            start_fs(c);
            frame_body(16, 8, -1, 0);
        end
        start_fs(c);                                   // fs9: relock
        push(c + 2, pk(1'b1, 1'b1, 1'b1, 1'b0, 16, 8));
        push(c + 3, pk(1'b1, 1'b0, 1'b1, 1'b0, 16, 8));
        fork
            frame_body(16, 8, -1, 0);
            begin
                repeat (70) step();
                filt_en_req = 1'b0;
                repeat (30) step();
                filt_en_req = 1'b1;
                repeat (50) step();
                filt_en_req = 1'b0;
            end
        join
        start_fs(c);                                   // fs10: bypass, no clear
        push(c + 2, pk(1'b0, 1'b0, 1'b1, 1'b0, 16, 8));
        fork
            frame_body(16, 8, -1, 0);
            begin
                repeat (100) step();
                filt_en_req = 1'b1;
            end
        join
        start_fs(c);                                   // fs11: filter re-engaged
        push(c + 2, pk(1'b1, 1'b1, 1'b1, 1'b0, 16, 8));
        push(c + 3, pk(1'b1, 1'b0, 1'b1, 1'b0, 16, 8));
        fork
            frame_body(16, 8, -1, 0);
            begin
                repeat (100) step();
                push(cyc + 1, pk(1'b0, 1'b0, 1'b0, 1'b0, 16, 8));
                init_over = 1'b0;
                repeat (5) step();
                init_over = 1'b1;
            end
        join
        for (int f = 12; f <= 13; f++) begin
            start_fs(c);
            frame_body(16, 8, -1, 0);
        end
        start_fs(c);                                   // fs14: lock regained
        push(c + 2, pk(1'b1, 1'b1, 1'b1, 1'b0, 16, 8));
        push(c + 3, pk(1'b1, 1'b0, 1'b1, 1'b0, 16, 8));
        frame_body(16, 8, -1, 0);
        repeat (10) step();

        n_checks = n_checks + 1;
        if (exp_val_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL missing_events got=%0d pending required=0", exp_val_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/filter_path_ctrl.md
Name: filter_path_ctrl

Overview:
Frame-synchronous controller for the 3x3 matrix / Gaussian filter datapath on the HDMI loop.
- Measures active geometry of the incoming video timing and declares timing lock after a run of consistent frames.
- Gates the filter/bypass select so it changes only at frame start.
- Issues a line-buffer clear pulse whenever the filtered path is (re)engaged.
- Sits between the input register stage and the matrix/filter instances; its select drives the output mux.

Parameters:
- W_BITS, 12, width of geometry counters and measured outputs.
- LOCK_FRAMES, 3, consecutive matching frames required to assert lock (1..15).
- VS_POL, 1, active level of video_vs (1 = active-high).

Ports:
- video_clk  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_over  in  1  HDMI chip configuration done; low holds the block in WAIT_INIT.
- video_vs  in  1  vertical sync, polarity per VS_POL.
- video_hs  in  1  horizontal sync (monitored only, not used for measurement).
- video_de  in  1  data enable.
- filt_en_req  in  1  software/switch request: 1 = filtered path, 0 = bypass; level, asynchronous to frames.
- filt_sel  out  1  registered path select to the output mux: 1 = filter output.
- lb_clr  out  1  one-cycle pulse clearing matrix line buffers.
- timing_lock  out  1  geometry stable.
- act_width  out  W_BITS  last locked active pixels per line.
- act_height  out  W_BITS  last locked active lines per frame.
- frame_err  out  1  one-cycle pulse on geometry mismatch.

Behaviour:
- Reset: all outputs 0; internal counters 0; state WAIT_INIT.
- Frame start (fs): rising edge of video_vs (VS_POL=1) or falling edge (VS_POL=0), detected with a 1-cycle registered delay. fs at the first sampled edge after reset is valid.
- Width measurement:
  - pix_cnt increments per cycle de=1, saturating at 2^W_BITS-1; cleared one cycle after de falls.
  - On de falling edge, line width = pix_cnt.
  - The first line of a frame sets cur_w. Any later line with a different width sets line_bad.
- Height measurement: line_cnt increments on each de rising edge, saturating; cleared at fs.
- Frame evaluation at each fs, covering the frame just ended:
  - good = !line_bad, cur_w != 0, line_cnt != 0.
  - match = good and (cur_w, line_cnt) equal to the stored previous geometry.
  - Store (cur_w, line_cnt) as previous; clear line_bad and cur_w.
- States (transitions evaluated at fs unless noted):
  - WAIT_INIT: init_over=1 -> MEASURE (immediately, not at fs).
  - MEASURE:
    - match increments match_cnt; otherwise match_cnt=0.
    - match_cnt reaching LOCK_FRAMES-1 with match -> LOCKED. On that transition: timing_lock=1 and act_width/act_height loaded.
  - LOCKED:
    - !match -> MEASURE. On that transition: timing_lock=0, match_cnt=0, frame_err pulses 1 cycle (same cycle as state change), filt_sel forced 0 in that cycle. act_width/height hold last locked values.
    - Retained values are an intentional hold, not a bug: verification checks for them.
  - init_over falling in any state -> WAIT_INIT asynchronously to frames, next cycle. Outputs then: filt_sel=0, timing_lock=0. act_* hold their values.
- filt_sel update:
  - Only at fs, and only when the state is LOCKED after the evaluation above. New value = filt_en_req sampled in the fs cycle, double-flopped.
  - Requests toggling mid-frame have no effect until the next fs.
  - In MEASURE or WAIT_INIT, filt_sel=0.
- lb_clr:
  - Pulses in the same cycle filt_sel goes 0->1.
  - Also pulses at every fs on which the state transitions MEASURE->LOCKED.
  - Two causes in the same cycle give a single pulse.
- Latency: fs is registered one cycle after the vs edge; filt_sel, timing_lock, lb_clr and frame_err are updated on the cycle after fs.
- Simultaneous events:
  - fs in the same cycle as a de falling edge: line width is accounted to the ending frame first.
  - Reset mid-frame: the first partial frame after reset is evaluated like any other and fails match (previous geometry = 0).
- Counter widths: W_BITS for pixel/line counters; match_cnt 4 bits.

Test Plan:
- Bench geometry: 16x8 active frames, 4-cycle horizontal blanking, 3 blank lines; init_over=1, filt_en_req=1 -> timing_lock=1 and act_width=16, act_height=8 after the 4th fs (LOCK_FRAMES=3). Same cycle: filt_sel=1 with a single lb_clr pulse.
- Locked at 16x8, one frame with line 5 at 15 pixels -> at next fs: frame_err pulse, timing_lock=0, filt_sel=0, act_width stays 16. Relock after 3 further good frames.
- Locked, filt_en_req toggles 1->0->1 mid-frame, ending at 0 before fs -> filt_sel stays 1 until fs, then 0. No lb_clr.
- init_over deasserted mid-frame while locked -> next cycle filt_sel=0, timing_lock=0. Reasserting init_over re-enters MEASURE; lock is regained after 3 matching frames.
- VS_POL=0 with inverted vs, 32x4 frames -> lock with act_width=32, act_height=4. Asserting rst_n low mid-line clears all outputs asynchronously.
